// File: rtl/board_state_if.sv
// Command/read bus of the chessboard store.
// The game controller and drawing path sit on the master side.
// The board_state block sits on the slave side.
interface board_state_if #(
  parameter int AW     = 6,
  parameter int CODE_W = 4
);
  logic [AW-1:0]     rd_xy;
  logic [CODE_W-1:0] rd_code;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [AW-1:0]     cmd_src;
  logic [AW-1:0]     cmd_dst;
  logic              done;
  logic              err;
  logic [CODE_W-1:0] captured_code;

  modport master (
    output rd_xy, cmd_valid, cmd_op, cmd_src, cmd_dst,
    input  rd_code, cmd_ready, done, err, captured_code
  );

  modport slave (
    input  rd_xy, cmd_valid, cmd_op, cmd_src, cmd_dst,
    output rd_code, cmd_ready, done, err, captured_code
  );
endinterface

// File: rtl/board_state.sv
// board_state: writable BOARD_N x BOARD_N chessboard store.
// - Has a registered read port for the drawing path.
// - Executes MOVE / INIT / CLEAR commands over a valid/ready handshake.
// - Define BOARD_UNDO_EN to enable a one-level UNDO record.
// - Without the macro, UNDO always completes with err=1.
// - Square address xy = {row, col}. Row 0 is the top rank; col 0 is the left file.
module board_state #(
  parameter int BOARD_N = 8,
  parameter int CODE_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  board_state_if.slave  bus
);

  localparam int RW = $clog2(BOARD_N);
  localparam int AW = 2 * RW;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MV_CHK   = 3'd1,
    MV_WR    = 3'd2,
    INIT_ROW = 3'd3,
    CLR_ROW  = 3'd4,
    UNDO_WR  = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_INIT  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_UNDO  = 2'b11;

  // Start-position piece code for a square; every square is empty unless the board is 8x8.
  function automatic logic [CODE_W-1:0] start_code(input int r, input int c);
    logic [3:0] v;
    v = 4'h0;
    if (BOARD_N == 8) begin
      case (r)
        0: begin
          case (c)
            0, 7:    v = 4'hA;
            1, 6:    v = 4'h9;
            2, 5:    v = 4'h8;
            3:       v = 4'hB;
            4:       v = 4'hC;
            default: v = 4'h0;
          endcase
        end
        1:       v = 4'h7;
        6:       v = 4'h1;
        7: begin
          case (c)
            0, 7:    v = 4'h4;
            1, 6:    v = 4'h3;
            2, 5:    v = 4'h2;
            3:       v = 4'h5;
            4:       v = 4'h6;
            default: v = 4'h0;
          endcase
        end
        default: v = 4'h0;
      endcase
    end else begin
      v = 4'h0;
    end
    return CODE_W'(v);
  endfunction

  logic [CODE_W-1:0] board_q [BOARD_N][BOARD_N];

  state_t            state_q, state_d;
  logic [AW-1:0]     src_q, dst_q;
  logic [CODE_W-1:0] piece_q, mcap_q;
  logic [RW-1:0]     row_q;
  logic              ready_q, done_q, err_q;
  logic [CODE_W-1:0] capout_q, rd_code_q;

  logic              done_d, err_d;
  logic [CODE_W-1:0] capout_d;
  logic [CODE_W-1:0] src_code_s, dst_code_s;
  logic              undo_ok_s;

  logic [RW-1:0] src_row_s, src_col_s, dst_row_s, dst_col_s, rd_row_s, rd_col_s;

  assign src_row_s  = src_q[AW-1:RW];
  assign src_col_s  = src_q[RW-1:0];
  assign dst_row_s  = dst_q[AW-1:RW];
  assign dst_col_s  = dst_q[RW-1:0];
  assign rd_row_s   = bus.rd_xy[AW-1:RW];
  assign rd_col_s   = bus.rd_xy[RW-1:0];
  assign src_code_s = board_q[src_row_s][src_col_s];
  assign dst_code_s = board_q[dst_row_s][dst_col_s];

`ifdef BOARD_UNDO_EN
  logic              undo_valid_q;
  logic [AW-1:0]     undo_src_q, undo_dst_q;
  logic [CODE_W-1:0] undo_piece_q, undo_cap_q;

  assign undo_ok_s = undo_valid_q;

  // Undo record: armed by each successful move, dropped by undo, init and clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      undo_valid_q <= 1'b0;
      undo_src_q   <= '0;
      undo_dst_q   <= '0;
      undo_piece_q <= '0;
      undo_cap_q   <= '0;
    end else begin
      case (state_q)
        MV_WR: begin
          undo_valid_q <= 1'b1;
          undo_src_q   <= src_q;
          undo_dst_q   <= dst_q;
          undo_piece_q <= piece_q;
          undo_cap_q   <= mcap_q;
        end
        INIT_ROW, CLR_ROW, UNDO_WR: undo_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  assign undo_ok_s = 1'b0;
`endif

  // Next-state and completion-status decode.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    capout_d = {CODE_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_MOVE:  state_d = MV_CHK;
            OP_INIT:  state_d = INIT_ROW;
            OP_CLEAR: state_d = CLR_ROW;
            OP_UNDO:  state_d = UNDO_WR;
            default:  state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      MV_CHK: begin
        if ((src_code_s == {CODE_W{1'b0}}) || (src_q == dst_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = MV_WR;
        end
      end
      MV_WR: begin
        state_d  = DONE;
        done_d   = 1'b1;
        capout_d = mcap_q;
      end
      INIT_ROW, CLR_ROW: begin
        if (row_q == RW'(BOARD_N - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      UNDO_WR: begin
        state_d = DONE;
        done_d  = 1'b1;
        err_d   = !undo_ok_s;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers: FSM state, latched operands, row counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      piece_q  <= '0;
      mcap_q   <= '0;
      row_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      capout_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == IDLE);
      done_q   <= done_d;
      err_q    <= err_d;
      capout_q <= capout_d;
      if ((state_q == IDLE) && bus.cmd_valid) begin
        src_q <= bus.cmd_src;
        dst_q <= bus.cmd_dst;
        row_q <= '0;
      end
      if (state_q == MV_CHK) begin
        piece_q <= src_code_s;
        mcap_q  <= dst_code_s;
      end
      if ((state_q == INIT_ROW) || (state_q == CLR_ROW)) begin
        row_q <= row_q + RW'(1);
      end
    end
  end

  // Board storage: reset loads the start position; writes depend on the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < BOARD_N; r++) begin
        for (int c = 0; c < BOARD_N; c++) begin
          board_q[r][c] <= start_code(r, c);
        end
      end
    end else begin
      case (state_q)
        INIT_ROW: begin
          for (int c = 0; c < BOARD_N; c++) begin
            board_q[row_q][c] <= start_code(int'(row_q), c);
          end
        end
        CLR_ROW: begin
          for (int c = 0; c < BOARD_N; c++) begin
            board_q[row_q][c] <= {CODE_W{1'b0}};
          end
        end
        MV_WR: begin
          board_q[dst_row_s][dst_col_s] <= piece_q;
          board_q[src_row_s][src_col_s] <= {CODE_W{1'b0}};
        end
`ifdef BOARD_UNDO_EN
        UNDO_WR: begin
          if (undo_valid_q) begin
            board_q[undo_src_q[AW-1:RW]][undo_src_q[RW-1:0]] <= undo_piece_q;
            board_q[undo_dst_q[AW-1:RW]][undo_dst_q[RW-1:0]] <= undo_cap_q;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Registered read port; a same-cycle write shows up one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_code_q <= '0;
    end else begin
      rd_code_q <= board_q[rd_row_s][rd_col_s];
    end
  end

  assign bus.rd_code       = rd_code_q;
  assign bus.cmd_ready     = ready_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.captured_code = capout_q;

endmodule

// File: tb/tb_board_state.sv
// Bench for board_state (8x8, 4-bit codes).
// It runs directed vectors, multi-cycle corner sequences and random commands.
// The random commands are checked against a square-array reference model.
module tb_board_state;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_state_if #(.AW(6), .CODE_W(4)) bus ();

  board_state #(.BOARD_N(8), .CODE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [5:0] src;
    logic [5:0] dst;
    logic       exp_err;
    logic [3:0] exp_cap;
    int         exp_lat;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] model [64];
  bit         m_undo_ok;
  logic [5:0] m_usrc, m_udst;
  logic [3:0] m_upiece, m_ucap;
  logic [3:0] black_back [8] = '{4'hA, 4'h9, 4'h8, 4'hB, 4'hC, 4'h8, 4'h9, 4'hA};
  logic [3:0] white_back [8] = '{4'h4, 4'h3, 4'h2, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4};

`ifdef BOARD_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_start();
    for (int i = 0; i < 64; i++) begin
      case (i / 8)
        0:       model[i] = black_back[i % 8];
        1:       model[i] = 4'h7;
        6:       model[i] = 4'h1;
        7:       model[i] = white_back[i % 8];
        default: model[i] = 4'h0;
      endcase
    end
    m_undo_ok = 1'b0;
  endtask

  // Reference behaviour of one command: expected err, captured code and latency.
  task automatic model_cmd(input logic [1:0] op, input logic [5:0] src, input logic [5:0] dst,
                           output logic e, output logic [3:0] cap, output int lat);
    e = 1'b0;
    cap = 4'h0;
    lat = 2;
    case (op)
      2'b00: begin
        if (model[src] == 4'h0 || src == dst) begin
          e = 1'b1;
        end else begin
          cap = model[dst];
          m_usrc = src; m_udst = dst; m_upiece = model[src]; m_ucap = model[dst];
          m_undo_ok = 1'b1;
          model[dst] = model[src];
          model[src] = 4'h0;
          lat = 3;
        end
      end
      2'b01: begin model_start(); lat = 9; end
      2'b10: begin
        for (int i = 0; i < 64; i++) model[i] = 4'h0;
        m_undo_ok = 1'b0;
        lat = 9;
      end
      default: begin
        if (UNDO_EN && m_undo_ok) begin
          model[m_usrc] = m_upiece;
          model[m_udst] = m_ucap;
          m_undo_ok = 1'b0;
        end else begin
          e = 1'b1;
        end
      end
    endcase
  endtask

  // Issue one command and wait (bounded) for done; lat counts cycles after the accept cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] src, input logic [5:0] dst,
                         output logic got, output logic e, output logic [3:0] cap, output int lat);
    int n;
    got = 1'b0; e = 1'b0; cap = 4'h0; lat = 0;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_src = src; bus.cmd_dst = dst;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 1;
    while (!got && n <= 40) begin
      if (bus.done) begin
        got = 1'b1; e = bus.err; cap = bus.captured_code; lat = n;
      end else begin
        @(posedge clk); #1; n++;
      end
    end
  endtask

  task automatic cmd_and_check(input string tag, input logic [1:0] op, input logic [5:0] src,
                               input logic [5:0] dst, input logic xe, input logic [3:0] xcap,
                               input int xlat);
    logic got, e;
    logic [3:0] cap;
    int lat;
    run_cmd(op, src, dst, got, e, cap, lat);
    chk({tag, " done"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " err"}, 32'(e), 32'(xe));
      chk({tag, " cap"}, 32'(cap), 32'(xcap));
      chk({tag, " latency"}, 32'(lat), 32'(xlat));
    end
  endtask

  task automatic read_sq(input logic [5:0] xy, output logic [3:0] code);
    bus.rd_xy = xy;
    @(posedge clk); #1;
    code = bus.rd_code;
  endtask

  task automatic sweep(input string tag);
    logic [3:0] code;
    for (int i = 0; i < 64; i++) begin
      read_sq(6'(i), code);
      chk($sformatf("%s xy%0d", tag, i), 32'(code), 32'(model[i]));
    end
  endtask

  vec_t tbl [6];

  initial begin
    logic got, e, xe;
    logic [3:0] cap, xcap, code;
    int lat, xlat, cyc;
    logic [1:0] op;
    logic [5:0] src, dst;
    int seen_done;

    bus.rd_xy = 6'd0; bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
    bus.cmd_src = 6'd0; bus.cmd_dst = 6'd0;

    tbl[0] = '{2'b00, 6'd52, 6'd36, 1'b0, 4'h0, 3};
    tbl[1] = '{2'b00, 6'd36, 6'd36, 1'b1, 4'h0, 2};
    tbl[2] = '{2'b00, 6'd20, 6'd28, 1'b1, 4'h0, 2};
    tbl[3] = '{2'b00, 6'd59, 6'd3,  1'b0, 4'hB, 3};
`ifdef BOARD_UNDO_EN
    tbl[4] = '{2'b11, 6'd0, 6'd0, 1'b0, 4'h0, 2};
`else
    tbl[4] = '{2'b11, 6'd0, 6'd0, 1'b1, 4'h0, 2};
`endif
    tbl[5] = '{2'b11, 6'd0, 6'd0, 1'b1, 4'h0, 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    chk("reset cap", 32'(bus.captured_code), 32'd0);
    chk("reset rd_code", 32'(bus.rd_code), 32'd0);
    model_start();
    sweep("start");

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      model_cmd(tbl[i].op, tbl[i].src, tbl[i].dst, xe, xcap, xlat);
      cmd_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].src, tbl[i].dst,
                    tbl[i].exp_err, tbl[i].exp_cap, tbl[i].exp_lat);
    end
    sweep("after vectors");

    // Read of a square in the cycle it is written returns the old value first
    bus.rd_xy = 6'd40;
    @(posedge clk); #1;
    code = model[40];
    model_cmd(2'b00, 6'd48, 6'd40, xe, xcap, xlat);
    run_cmd(2'b00, 6'd48, 6'd40, got, e, cap, lat);
    chk("rw done", 32'(got), 32'd1);
    chk("rw old value", 32'(bus.rd_code), 32'(code));
    @(posedge clk); #1;
    chk("rw new value", 32'(bus.rd_code), 32'(model[40]));

    // Clear then init
    model_cmd(2'b10, 6'd0, 6'd0, xe, xcap, xlat);
    cmd_and_check("clear", 2'b10, 6'd0, 6'd0, 1'b0, 4'h0, 9);
    sweep("cleared");
    model_cmd(2'b01, 6'd0, 6'd0, xe, xcap, xlat);
    cmd_and_check("init", 2'b01, 6'd0, 6'd0, 1'b0, 4'h0, 9);
    sweep("init");

    // Random commands against the model
    for (int k = 0; k < 60; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 15) op = 2'b00; else if (r < 18) op = 2'b11; else if (r < 19) op = 2'b01; else op = 2'b10;
      src = 6'($urandom_range(0, 63));
      dst = 6'($urandom_range(0, 63));
      if (op == 2'b00 && $urandom_range(0, 3) != 0) begin
        for (int j = 0; j < 64; j++) begin
          if (model[6'(src + 6'(j))] != 4'h0) begin
            src = 6'(src + 6'(j));
            break;
          end
        end
      end
      model_cmd(op, src, dst, xe, xcap, xlat);
      cmd_and_check($sformatf("rnd%0d op%0d", k, op), op, src, dst, xe, xcap, xlat);
      for (int j = 0; j < 2; j++) begin
        dst = 6'($urandom_range(0, 63));
        read_sq(dst, code);
        chk($sformatf("rnd%0d read xy%0d", k, dst), 32'(code), 32'(model[dst]));
      end
    end
    sweep("after random");

    // Reset in the middle of an INIT sweep
    model_cmd(2'b10, 6'd0, 6'd0, xe, xcap, xlat);
    cmd_and_check("pre-reset clear", 2'b10, 6'd0, 6'd0, 1'b0, 4'h0, 9);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    seen_done = 0;
    for (cyc = 1; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    rst = 1'b1;
    #1;
    chk("midreset ready", 32'(bus.cmd_ready), 32'd1);
    chk("midreset rd_code", 32'(bus.rd_code), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    chk("midreset no done", 32'(seen_done), 32'd0);
    chk("midreset ready after", 32'(bus.cmd_ready), 32'd1);
    model_start();
    sweep("after midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
